// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Smallest ratio the divider datapath can produce.
  localparam int unsigned MIN_DIV = 2;

  // Number of high cycles in one period of ratio n (rounds up for odd n).
  function automatic int unsigned half_high(input int unsigned n);
    return (n >> 1) + (n & 32'd1);
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio configuration channel: valid/ready transfer plus an error pulse.
interface clk_div_ctrl_if #(
  parameter int unsigned CW = 8
);

  logic          cfg_valid;
  logic [CW-1:0] cfg_div;
  logic          cfg_ready;
  logic          cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_ctrl_div_counter.sv
// Period counter, active-ratio register and registered output decode.
// Outputs are registered from next-cycle values so they line up with cnt.
module div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned CW          = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,     // take ratio as cur_div at this edge
  input  logic          run,      // controller busy in the next cycle
  input  logic [CW-1:0] ratio,
  output logic [CW-1:0] cur_div,
  output logic          last,     // cnt is in the final cycle of the period
  output logic          div_out,
  output logic          odd_trim,
  output logic          div_tick
);

  logic          run_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] div_nxt;
  logic [CW-1:0] h_nxt;

  // Next counter value, next ratio and next high-phase length.
  always_comb begin
    last    = (cnt == cur_div - CW'(1));
    div_nxt = load ? ratio : cur_div;
    cnt_nxt = '0;
    if (run_q && !last) begin
      cnt_nxt = cnt + CW'(1);
    end
    h_nxt   = CW'(half_high(32'(div_nxt)));
  end

  // Counter, ratio and decoded outputs; reset aborts the period at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt      <= '0;
      cur_div  <= CW'(DEFAULT_DIV);
      div_out  <= 1'b0;
      odd_trim <= 1'b0;
      div_tick <= 1'b0;
    end else begin
      run_q    <= run;
      cnt      <= cnt_nxt;
      cur_div  <= div_nxt;
      div_out  <= run && (cnt_nxt < h_nxt);
      odd_trim <= run && div_nxt[0] && (cnt_nxt == h_nxt - CW'(1));
      div_tick <= run && (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the integer clock divider: run/drain sequencing,
// ratio handshake and glitch-free ratio changes at period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CW          = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  clk_div_ctrl_if.slave  cfg,
  output logic [CW-1:0]  cur_div,
  output logic           div_out,
  output logic           odd_trim,
  output logic           div_tick,
  output logic           busy
);

  state_t        state;
  state_t        state_nxt;
  logic          pend_valid;
  logic [CW-1:0] pend_div;
  logic          last;
  logic          load;
  logic [CW-1:0] ratio;
  logic          take;
  logic          xfer;

  assign cfg.cfg_ready = !pend_valid;
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign take          = xfer && (cfg.cfg_div >= CW'(MIN_DIV));
  assign busy          = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and ratio-load selection.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ratio     = cfg.cfg_div;
    unique case (state)
      IDLE:  if (en) state_nxt = RUN;
      RUN:   if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en) begin
          state_nxt = RUN;
        end else if (last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Idle: a legal ratio takes effect immediately. Busy: only at a boundary,
    // either from the pending slot or from a transfer landing on that cycle.
    if (state == IDLE) begin
      load = take;
    end else if (last) begin
      if (pend_valid) begin
        load  = 1'b1;
        ratio = pend_div;
      end else begin
        load = take;
      end
    end
  end

  // Pending-ratio slot and illegal-ratio error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_div    <= '0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= xfer && !take;
      if (busy && last && pend_valid) begin
        pend_valid <= 1'b0;
      end else if (busy && !last && take) begin
        pend_valid <= 1'b1;
        pend_div   <= cfg.cfg_div;
      end
    end
  end

  div_counter #(
    .CW          (CW),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .run      (state_nxt != IDLE),
    .ratio    (ratio),
    .cur_div  (cur_div),
    .last     (last),
    .div_out  (div_out),
    .odd_trim (odd_trim),
    .div_tick (div_tick)
  );

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the team's integer clock-divider datapath.
- Holds the active divide ratio N and accepts new ratios over a valid/ready handshake.
- Applies a new ratio only at an output-period boundary, so the divided output never glitches.
- Sequences start/stop of the divider, and drains a running divider to a whole period before stopping.
- Emits a posedge-domain divided level plus an odd_trim hint; a downstream negedge cell uses odd_trim to build 50% duty for odd N.

Parameters:
CW, 8, width of ratio and counter.
DEFAULT_DIV, 3, ratio loaded at reset; must satisfy 2 <= DEFAULT_DIV <= 2^CW-1.

Ports:
clk  in  1  single system clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
en  in  1  run request; level.
cfg_valid  in  1  new ratio offered.
cfg_div  in  CW  requested ratio N.
cfg_ready  out  1  controller can accept a ratio.
cfg_err  out  1  one-cycle pulse: accepted ratio was illegal (< 2).
cur_div  out  CW  ratio in effect for the current period.
div_out  out  1  divided clock level, posedge grid.
odd_trim  out  1  high in the last high cycle when N is odd.
div_tick  out  1  one-cycle pulse at the first cycle of each period.
busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, pend_valid=0, cur_div=DEFAULT_DIV, cfg_ready=1, and cfg_err, div_out, odd_trim, div_tick, busy all 0. Reset mid-period aborts immediately and discards any pending ratio.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when en=1; the first div_tick appears in the cycle after en is sampled high.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1 again; the period continues with no restart.
  - DRAIN -> IDLE after the cycle with cnt==cur_div-1.
- Counter: cnt runs 0..cur_div-1 and wraps to 0; it is held at 0 in IDLE. cnt and cur_div are CW bits with no overflow; the maximum N is 2^CW-1.
- Output decode (registered, aligned with cnt):
  - H = (N>>1) + N[0].
  - div_out = busy && cnt < H.
  - odd_trim = busy && N[0] && cnt == H-1.
  - div_tick = busy && cnt == 0.
- Handshake: a transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = !pend_valid.
  - cfg_div < 2: cfg_err pulses the next cycle; the ratio is discarded and pend_valid is unchanged.
  - In IDLE: cur_div is updated the next cycle, and pend_valid stays 0.
  - In RUN/DRAIN: the ratio is latched into pend_div and pend_valid=1.
- Boundary apply: in the cycle cnt==cur_div-1 with pend_valid=1, cur_div<=pend_div, pend_valid<=0, cnt<=0. The new period starts with the new ratio.
- Transfer coinciding with the boundary cycle (pend_valid=0): the ratio applies at that boundary directly, and pend_valid stays 0.
- A pending ratio at DRAIN->IDLE is applied at that same boundary.
- cfg_valid may be held; the producer keeps cfg_div stable until the transfer.

Decomposition:
- Package clk_div_pkg holds:
  - the state enum {IDLE, RUN, DRAIN};
  - MIN_DIV=2;
  - a function half_high(N) returning H.
- Sub-module div_counter holds cnt, the wrap/load logic and the output decode, with inputs load, run, ratio.
- clk_div_ctrl holds the FSM, the handshake and the pending register.

Test Plan:
1. Reset, en=1, N=3 -> div_tick every 3 cycles; div_out 1,1,0 repeating; odd_trim high at cnt=1; cur_div=3.
2. While running at N=3, offer cfg_div=4 at cnt=0:
   - cfg_ready drops for 2 cycles;
   - after wrap, periods are 4 cycles, div_out 1,1,0,0, odd_trim=0.
3. cfg_div=1 in RUN -> cfg_err pulses 1 cycle, cur_div stays 3, the period is unaffected, and cfg_ready stays 1.
4. N=5, drop en at cnt=0 -> cnt continues 1..4, then IDLE; busy=0 and div_out=0 from the following cycle. Re-raising en at cnt=2 during DRAIN keeps the period unbroken.
5. Assert rst mid-period with pend_valid=1 -> all outputs 0 immediately; after release, cur_div=3, cfg_ready=1, and no pending ratio is applied.
6. cfg_div=255 (CW=8) then cfg_div=2:
   - 255-cycle period with 128 high cycles and odd_trim at cnt=127;
   - the switch to N=2 happens exactly at cnt=254;
   - then div_out alternates 1,0.
